// File: rtl/usb_tx_bit_timer.sv
// Fractional-divider USB TX bit/byte timer. Defining STUFF_STALL_EN adds stuff_req, which marks stuffed bits as uncounted.
// Outputs are registered, and a strobe rises on the edge after cnt==P-1. There is no backpressure: enable low or clear returns all state to reset values.
module usb_tx_bit_timer #(
  parameter int DIV_INT       = 8,
  parameter int DIV_NUM       = 1,
  parameter int DIV_DEN       = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int BYTE_CNT_W    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             clear,
`ifdef STUFF_STALL_EN
  input  logic                             stuff_req,
`endif
  output logic                             bit_strobe,
  output logic                             byte_strobe,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_index,
  output logic [BYTE_CNT_W-1:0]            byte_count
);

  localparam int CNT_W = $clog2(DIV_INT + 1);
  localparam int ACC_W = (DIV_DEN > 1) ? $clog2(DIV_DEN) : 1;
  localparam int SUM_W = $clog2(2 * DIV_DEN + 1) + 1;
  localparam int IDX_W = $clog2(BITS_PER_BYTE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_BYTE - 1);

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_last;
  logic             carry;
  logic             period_end;
  logic             count_bit;

  // The period is stretched by one clock whenever the fractional accumulator overflows.
  always_comb begin
    acc_sum    = SUM_W'(acc) + SUM_W'(DIV_NUM);
    carry      = (acc_sum >= SUM_W'(DIV_DEN));
    acc_next   = carry ? ACC_W'(acc_sum - SUM_W'(DIV_DEN)) : ACC_W'(acc_sum);
    cnt_last   = carry ? CNT_W'(DIV_INT) : CNT_W'(DIV_INT - 1);
    period_end = (cnt == cnt_last);
  end

`ifdef STUFF_STALL_EN
  assign count_bit = ~stuff_req;
`else
  assign count_bit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      bit_index   <= '0;
      byte_count  <= '0;
      bit_strobe  <= 1'b0;
      byte_strobe <= 1'b0;
    end else if (clear || !enable) begin
      cnt         <= '0;
      acc         <= '0;
      bit_index   <= '0;
      byte_count  <= '0;
      bit_strobe  <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      bit_strobe  <= period_end;
      byte_strobe <= period_end && count_bit && (bit_index == IDX_LAST);
      if (period_end) begin
        cnt <= '0;
        acc <= acc_next;
        // A stuffed bit uses up its whole period but does not occupy a data slot.
        if (count_bit) begin
          if (bit_index == IDX_LAST) begin
            bit_index  <= '0;
            byte_count <= byte_count + BYTE_CNT_W'(1);
          end else begin
            bit_index <= bit_index + IDX_W'(1);
          end
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_bit_timer.sv
// Randomised scoreboard bench for usb_tx_bit_timer: default instance plus a 4-clk integer-divide, 2-bit byte-count instance.
module tb_usb_tx_bit_timer;

  localparam int A_INT = 8, A_NUM = 1, A_DEN = 3, A_BPB = 8, A_BW = 8;
  localparam int B_INT = 4, B_NUM = 0, B_DEN = 1, B_BPB = 3, B_BW = 2;
`ifdef STUFF_STALL_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clear = 1'b0;
`ifdef STUFF_STALL_EN
  logic stuff_req = 1'b0;
`endif
  logic                  a_bs, a_ys, b_bs, b_ys;
  logic [2:0]            a_idx;
  logic [1:0]            b_idx;
  logic [A_BW-1:0]       a_bc;
  logic [B_BW-1:0]       b_bc;

  always #5 clk = ~clk;

  usb_tx_bit_timer #(.DIV_INT(A_INT), .DIV_NUM(A_NUM), .DIV_DEN(A_DEN),
                     .BITS_PER_BYTE(A_BPB), .BYTE_CNT_W(A_BW)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
`ifdef STUFF_STALL_EN
    .stuff_req(stuff_req),
`endif
    .bit_strobe(a_bs), .byte_strobe(a_ys), .bit_index(a_idx), .byte_count(a_bc));

  usb_tx_bit_timer #(.DIV_INT(B_INT), .DIV_NUM(B_NUM), .DIV_DEN(B_DEN),
                     .BITS_PER_BYTE(B_BPB), .BYTE_CNT_W(B_BW)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
`ifdef STUFF_STALL_EN
    .stuff_req(stuff_req),
`endif
    .bit_strobe(b_bs), .byte_strobe(b_ys), .bit_index(b_idx), .byte_count(b_bc));

  typedef struct { int run; int bits; int counted; } mstate_t;
  typedef struct { bit bs; bit ys; int idx; int bc; } exp_t;
  typedef struct { exp_t a; exp_t b; } sb_item_t;

  sb_item_t q[$];
  mstate_t  ma = '{0, 0, 0};
  mstate_t  mb = '{0, 0, 0};
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int s_log[$];
  int y_log[$];
  int yc_log[$];
  int b_strobes = 0;
  int b_yc_log[$];

  // Bit n (1-based) of a run ends on edge n*DIV_INT + floor(n*DIV_NUM/DIV_DEN).
  function automatic mstate_t step(input mstate_t s, input bit act, input bit stuffed,
                                   input int di, input int dn, input int dd,
                                   input int bpb, input int bw, output exp_t e);
    mstate_t n = s;
    e.bs = 1'b0;
    e.ys = 1'b0;
    if (!act) begin
      n.run = 0; n.bits = 0; n.counted = 0;
    end else begin
      n.run++;
      if (n.run == (n.bits + 1) * di + ((n.bits + 1) * dn) / dd) begin
        n.bits++;
        e.bs = 1'b1;
        if (!stuffed) begin
          n.counted++;
          e.ys = (n.counted % bpb == 0);
        end
      end
    end
    e.idx = n.counted % bpb;
    e.bc  = (n.counted / bpb) % (1 << bw);
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit act, input bit stf);
    sb_item_t it;
    bit s;
    s  = STUFF && stf;
    ma = step(ma, act, s, A_INT, A_NUM, A_DEN, A_BPB, A_BW, it.a);
    mb = step(mb, act, s, B_INT, B_NUM, B_DEN, B_BPB, B_BW, it.b);
    q.push_back(it);
  endtask

  task automatic drive(input bit en, input bit clr, input bit stf, input bit r);
    @(negedge clk);
    rst    = r;
    enable = en;
    clear  = clr;
`ifdef STUFF_STALL_EN
    stuff_req = stf;
`endif
    push_exp(en && !clr && !r, stf);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst a.bit_strobe", int'(a_bs), 0);
    chk("async_rst a.byte_strobe", int'(a_ys), 0);
    chk("async_rst a.bit_index", int'(a_idx), 0);
    chk("async_rst a.byte_count", int'(a_bc), 0);
    chk("async_rst b.bit_index", int'(b_idx), 0);
    chk("async_rst b.byte_count", int'(b_bc), 0);
    push_exp(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_logs();
    s_log.delete(); y_log.delete(); yc_log.delete(); b_yc_log.delete();
    b_strobes = 0;
  endtask

  // Monitor: pops one expectation per clock edge and compares both instances.
  initial begin
    sb_item_t it;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #2;
      if (a_bs) s_log.push_back(edge_cnt);
      if (a_ys) begin y_log.push_back(edge_cnt); yc_log.push_back(int'(a_bc)); end
      if (b_bs) b_strobes++;
      if (b_ys) b_yc_log.push_back(int'(b_bc));
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("a.bit_strobe", int'(a_bs), int'(it.a.bs));
        chk("a.byte_strobe", int'(a_ys), int'(it.a.ys));
        chk("a.bit_index", int'(a_idx), it.a.idx);
        chk("a.byte_count", int'(a_bc), it.a.bc);
        chk("b.bit_strobe", int'(b_bs), int'(it.b.bs));
        chk("b.byte_strobe", int'(b_ys), int'(it.b.ys));
        chk("b.bit_index", int'(b_idx), it.b.idx);
        chk("b.byte_count", int'(b_bc), it.b.bc);
      end
    end
  end

  initial begin
    int base, base2;
    bit en, clr, stf;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Enable held from reset release: strobe timing, byte timing, wrap of the narrow counter.
    base = edge_cnt + 1;
    clear_logs();
    repeat (200) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("run200 strobe count", s_log.size(), 24);
    if (s_log.size() >= 3) begin
      chk("first strobe edge", s_log[0] - base, 8);
      chk("second strobe edge", s_log[1] - base, 16);
      chk("third strobe edge", s_log[2] - base, 25);
    end else chk("strobe log depth", s_log.size(), 3);
    if (y_log.size() >= 1) begin
      chk("first byte edge", y_log[0] - base, 66);
      chk("first byte count", yc_log[0], 1);
    end else chk("byte log depth", y_log.size(), 1);
    chk("b run200 strobe count", b_strobes, 50);
    if (b_yc_log.size() >= 4) begin
      chk("b byte_count #1", b_yc_log[0], 1);
      chk("b byte_count #2", b_yc_log[1], 2);
      chk("b byte_count #3", b_yc_log[2], 3);
      chk("b byte_count #4", b_yc_log[3], 0);
    end else chk("b byte log depth", b_yc_log.size(), 4);

    // Enable dropped mid-bit after edge 12, then re-raised.
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    base = edge_cnt + 1;
    clear_logs();
    repeat (12) drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    base2 = edge_cnt + 1;
    repeat (9) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reenable strobe count", s_log.size(), 2);
    if (s_log.size() == 2) chk("reenable strobe edge", s_log[1] - base2, 8);

    // Clear pulsed while enabled with cnt=5.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    base = edge_cnt + 1;
    clear_logs();
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (9) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clear strobe count", s_log.size(), 1);
    if (s_log.size() == 1) chk("clear strobe edge", s_log[0] - base, 14);

`ifdef STUFF_STALL_EN
    // Third bit stuffed: nine strobes before the first byte.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    clear_logs();
    for (int i = 1; i <= 80; i++) drive(1'b1, 1'b0, (i == 25), 1'b0);
    if (s_log.size() >= 9 && y_log.size() >= 1) chk("stuffed byte edge", y_log[0], s_log[8]);
    else chk("stuffed log depth", y_log.size(), 1);
`endif

    // Randomised long run with rare enable drops, clears, stuffing and one async reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        repeat (30) drive(1'b1, 1'b0, 1'b0, 1'b0);
        async_reset();
      end
      en  = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 299) == 0);
      stf = ($urandom_range(0, 6) == 0);
      drive(en, clr, stf, 1'b0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
